// File: rtl/uart_tx_feeder.sv
// Byte FIFO and start/busy sequencer feeding a UART transmitter.
// Bytes are popped one at a time and handed over via tx_start/tx_busy.
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    wr_en,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_W:0]         count,
    output logic                    overflow,
    output logic                    ack_err,
    input  logic                    clr_err,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic                    sending
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      ACK_MAX  = 8'(ACK_TIMEOUT);

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    ack_q, ack_d;
    logic                    start_q, start_d;
    logic [7:0]              tmr_q, tmr_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    push, pop, ack_set;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign ack_err  = ack_q;
    assign tx_data  = data_q;
    assign tx_start = start_q;
    assign sending  = (state_q != IDLE);

    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty && !tx_busy;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        ack_d = ack_q;
        if (ack_set) begin
            ack_d = 1'b1;
        end else if (clr_err) begin
            ack_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        tmr_d   = tmr_q;
        data_d  = data_q;
        ack_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    tmr_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == ACK_MAX) begin
                    ack_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    start_d = 1'b1;
                    tmr_d   = tmr_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            start_q  <= 1'b0;
            tmr_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            tmr_q    <= tmr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized checks of uart_tx_feeder against a
// transmitter model and a byte-order scoreboard.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int ACK_T = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       full, empty;
    logic [4:0] count;
    logic       overflow, ack_err;
    logic       clr_err = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       sending;

    int n_chk = 0;
    int n_err = 0;

    // transmitter model: 0 normal, 1 busy tied low, 2 stalled, 3 random
    int xm_mode = 1;
    int xm_len  = 20;
    int xm_dly  = 0;
    int xm_hold = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    uart_tx_feeder dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ack_err  (ack_err),
        .clr_err  (clr_err),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .sending  (sending)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Busy rises on the third cycle tx_start is seen, then holds xm_len cycles.
    always @(posedge clk) begin
        case (xm_mode)
            1: begin
                tx_busy <= 1'b0;
                xm_dly = 0;
                xm_hold = 0;
            end
            2: begin
                tx_busy <= 1'b1;
                xm_dly = 0;
                xm_hold = 0;
            end
            3: begin
                tx_busy <= 1'($urandom);
                xm_dly = 0;
                xm_hold = 0;
            end
            default: begin
                if (xm_hold > 0) begin
                    if (xm_hold == 1) tx_busy <= 1'b0;
                    xm_hold = xm_hold - 1;
                end else if (tx_start && xm_dly == 2) begin
                    tx_busy <= 1'b1;
                    xm_hold = xm_len;
                    xm_dly = 0;
                    rx_q.push_back(tx_data);
                end else begin
                    tx_busy <= 1'b0;
                    if (tx_start) xm_dly = xm_dly + 1;
                end
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] b);
        wr_data = b;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int n = 0;
        while (tx_busy !== lvl && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic wait_drain(input int max, input string tag);
        int n = 0;
        while (!(empty === 1'b1 && sending === 1'b0 && tx_busy === 1'b0)
               && n < max) begin
            tick();
            n++;
        end
        chk(tag, {30'd0, empty, sending}, 32'b10);
    endtask

    task automatic cmp_rx(input string tag);
        logic [7:0] got;
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            chk(tag, 32'(got), 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int hi;
        // reset is asynchronous: check before any clock edge
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_txstart", tx_start, 0);
        chk("rst_sending", sending, 0);
        xm_mode = 3;
        repeat (6) begin
            wr_en = 1'($urandom);
            wr_data = 8'($urandom);
            clr_err = 1'($urandom);
            tick();
        end
        chk("rst_hold_count", count, 0);
        chk("rst_hold_start", tx_start, 0);
        chk("rst_hold_send", sending, 0);
        chk("rst_hold_ovf", overflow, 0);
        wr_en = 1'b0;
        clr_err = 1'b0;
        xm_mode = 1;
        tick();
        tick();
        #2 reset = 1'b1;
        tick();

        // single byte
        xm_mode = 0;
        xm_len = 1000;
        write(8'hA5);
        chk("sb_count_n", count, 1);
        tick();
        chk("sb_txdata_n1", tx_data, 8'hA5);
        chk("sb_start_n1", tx_start, 0);
        chk("sb_send_n1", sending, 1);
        tick();
        chk("sb_start_n2", tx_start, 1);
        wait_busy(1'b1, 20, "sb_busy_rise");
        chk("sb_start_hold", tx_start, 1);
        tick();
        chk("sb_start_fall", tx_start, 0);
        chk("sb_send_wait", sending, 1);
        wait_busy(1'b0, 1100, "sb_busy_fall");
        tick();
        chk("sb_send_end", sending, 0);
        chk("sb_empty_end", empty, 1);
        exp_q.push_back(8'hA5);
        cmp_rx("sb_rx");

        // burst with stalled transmitter, then overflow
        xm_mode = 2;
        tick();
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            write(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("bu_full", full, 1);
        chk("bu_count", count, 16);
        chk("bu_ovf", overflow, 0);
        write(8'hFF);
        chk("ov_flag", overflow, 1);
        chk("ov_count", count, 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ov_clear", overflow, 0);
        xm_len = 20;
        xm_mode = 0;
        wait_drain(2000, "bu_drain");
        chk("bu_ovf_end", overflow, 0);
        cmp_rx("bu_rx");

        // ack timeout
        xm_mode = 1;
        tick();
        write(8'h3C);
        tick();
        chk("to_send", sending, 1);
        chk("to_count", count, 0);
        tick();
        hi = 0;
        while (tx_start === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        chk("to_width", hi, ACK_T);
        chk("to_ackerr", ack_err, 1);
        chk("to_idle", sending, 0);
        chk("to_count_end", count, 0);
        cmp_rx("to_rx");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clear", ack_err, 0);

        // randomized traffic against scoreboard
        xm_len = $urandom_range(3, 8);
        xm_mode = 0;
        repeat (12) begin
            logic [7:0] b;
            b = 8'($urandom);
            write(b);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 4)) tick();
        end
        wait_drain(2000, "rn_drain");
        chk("rn_ovf", overflow, 0);
        chk("rn_ackerr", ack_err, 0);
        cmp_rx("rn_rx");

        // reset during WAIT_DONE with five bytes queued
        xm_len = 50;
        for (int i = 0; i < 6; i++) write(8'(8'h40 + i));
        chk("mr_count_q", count, 5);
        wait_busy(1'b1, 20, "mr_busy");
        tick();
        chk("mr_send", sending, 1);
        chk("mr_start", tx_start, 0);
        #2 reset = 1'b0;
        #1;
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_sending", sending, 0);
        chk("mr_txdata", tx_data, 0);
        tick();
        tick();
        #2 reset = 1'b1;
        wait_busy(1'b0, 100, "mr_busy_end");
        tick();
        rx_q.delete();
        write(8'h77);
        exp_q.push_back(8'h77);
        wait_drain(500, "mr_drain");
        cmp_rx("mr_rx");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
